// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (icache refill / data) arbiter onto a single memory port
module mem_port_arbiter #(
    parameter int I_BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_addrok,
    output logic        d_dataok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_size,
    output logic [1:0]  m_len,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    input  logic [31:0] m_rdata,
    input  logic        m_wresp,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        I_REQ,
        I_RESP,
        D_REQ,
        D_RESP
    } state_t;

    localparam logic [1:0] BURST_LEN_M1 = 2'(I_BURST_LEN - 1);
    localparam logic [2:0] BURST_BEATS  = 3'(I_BURST_LEN);

    state_t      state_q, state_d;
    logic        last_inst_q, last_inst_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic        proto_err_q, proto_err_d;
    logic        burst_q, burst_d;
    logic        wr_q, wr_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;

    logic        grant_inst;
    logic        grant_data;
    logic [2:0]  beats_seen;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            last_inst_q <= 1'b1;
            beat_cnt_q  <= 2'd0;
            proto_err_q <= 1'b0;
            burst_q     <= 1'b0;
            wr_q        <= 1'b0;
            size_q      <= 3'd0;
            addr_q      <= 32'd0;
            wstrb_q     <= 4'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            last_inst_q <= last_inst_d;
            beat_cnt_q  <= beat_cnt_d;
            proto_err_q <= proto_err_d;
            burst_q     <= burst_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_inst_d = last_inst_q;
        beat_cnt_d  = beat_cnt_q;
        proto_err_d = proto_err_q;
        burst_d     = burst_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;

        grant_inst  = 1'b0;
        grant_data  = 1'b0;
        beats_seen  = 3'(beat_cnt_q) + 3'd1;

        i_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        i_ret_data  = 32'd0;
        d_addrok    = 1'b0;
        d_dataok    = 1'b0;
        d_rdata     = 32'd0;
        m_req       = 1'b0;
        m_wr        = 1'b0;
        m_size      = 3'd0;
        m_len       = 2'd0;
        m_addr      = 32'd0;
        m_wstrb     = 4'd0;
        m_wdata     = 32'd0;

        case (state_q)
            IDLE: begin
                // Grant pulses are gated by resetn so they stay low while reset is held.
                grant_inst = resetn && i_rd_req && (!d_req || !last_inst_q);
                grant_data = resetn && d_req && !grant_inst;
                if (grant_inst) begin
                    i_rd_rdy    = 1'b1;
                    last_inst_d = 1'b1;
                    burst_d     = (i_rd_type == 3'b100);
                    wr_d        = 1'b0;
                    size_d      = 3'b010;
                    addr_d      = i_rd_addr;
                    wstrb_d     = 4'd0;
                    wdata_d     = 32'd0;
                    state_d     = I_REQ;
                end else if (grant_data) begin
                    d_addrok    = 1'b1;
                    last_inst_d = 1'b0;
                    burst_d     = 1'b0;
                    wr_d        = d_wr;
                    size_d      = d_size;
                    addr_d      = d_addr;
                    wstrb_d     = d_wstrb;
                    wdata_d     = d_wdata;
                    state_d     = D_REQ;
                end
                if (m_rvalid || m_wresp) begin
                    proto_err_d = 1'b1;
                end
            end

            I_REQ, D_REQ: begin
                m_req   = 1'b1;
                m_wr    = wr_q;
                m_size  = size_q;
                m_len   = burst_q ? BURST_LEN_M1 : 2'd0;
                m_addr  = addr_q;
                m_wstrb = wstrb_q;
                m_wdata = wdata_q;
                if (m_addr_ok) begin
                    state_d = (state_q == I_REQ) ? I_RESP : D_RESP;
                end
                if (m_rvalid || m_wresp) begin
                    proto_err_d = 1'b1;
                end
            end

            I_RESP: begin
                i_ret_valid = m_rvalid;
                i_ret_last  = m_rlast;
                i_ret_data  = m_rdata;
                if (m_rvalid) begin
                    if (m_rlast) begin
                        if (beats_seen != (burst_q ? BURST_BEATS : 3'd1)) begin
                            proto_err_d = 1'b1;
                        end
                        beat_cnt_d = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
                if (m_wresp) begin
                    proto_err_d = 1'b1;
                end
            end

            D_RESP: begin
                if (wr_q) begin
                    d_dataok = m_wresp;
                    if (m_wresp) begin
                        state_d = IDLE;
                    end
                    if (m_rvalid) begin
                        proto_err_d = 1'b1;
                    end
                end else begin
                    d_dataok = m_rvalid;
                    d_rdata  = m_rdata;
                    if (m_rvalid) begin
                        state_d = IDLE;
                    end
                    if (m_wresp) begin
                        proto_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_rd_req;
    logic [2:0]  i_rd_type;
    logic [31:0] i_rd_addr;
    logic        i_rd_rdy;
    logic        i_ret_valid;
    logic        i_ret_last;
    logic [31:0] i_ret_data;
    logic        d_req;
    logic        d_wr;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_addrok;
    logic        d_dataok;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_wr;
    logic [2:0]  m_size;
    logic [1:0]  m_len;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_rvalid;
    logic        m_rlast;
    logic [31:0] m_rdata;
    logic        m_wresp;
    logic        proto_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.I_BURST_LEN(L)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_ret_data(i_ret_data),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_addrok(d_addrok),
        .d_dataok(d_dataok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_len(m_len),
        .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_rdata(m_rdata), .m_wresp(m_wresp), .proto_err(proto_err)
    );

    int total = 0;
    int bad   = 0;
    bit model_last_inst;
    bit model_err;

    int          pat, adly, rdly, i_last;
    logic        r_wr;
    logic [2:0]  r_size, r_typ;
    logic [31:0] r_addr, r_iaddr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) chkb("grant_overlap", i_rd_rdy & d_addrok, 1'b0);
    end

    task automatic txn_data(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                            input logic [3:0] wstrb, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ad, input int rd, input bit keep);
        d_req = 1'b1; d_wr = wr; d_size = size; d_addr = addr; d_wstrb = wstrb; d_wdata = wdata;
        #1;
        chkb("d_addrok_grant", d_addrok, 1'b1);
        chkb("i_rd_rdy_quiet", i_rd_rdy, 1'b0);
        model_last_inst = 1'b0;
        @(posedge clk); #1;
        if (!keep) begin
            d_req = 1'b0; d_addr = ~addr; d_wdata = ~wdata; d_wstrb = ~wstrb; d_wr = ~wr;
        end
        #1;
        chkb("d_addrok_pulse", d_addrok, 1'b0);
        chkb("d_m_req", m_req, 1'b1);
        chkb("d_m_wr", m_wr, wr);
        chk("d_m_len", 32'(m_len), 32'd0);
        chk("d_m_size", 32'(m_size), 32'(size));
        chk("d_m_addr", m_addr, addr);
        chk("d_m_wstrb", 32'(m_wstrb), 32'(wstrb));
        chk("d_m_wdata", m_wdata, wdata);
        repeat (ad) begin
            @(posedge clk); #2;
            chkb("d_m_req_hold", m_req, 1'b1);
            chk("d_m_addr_hold", m_addr, addr);
        end
        m_addr_ok = 1'b1;
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        #1;
        chkb("d_m_req_drop", m_req, 1'b0);
        repeat (rd) begin
            chkb("d_dataok_wait", d_dataok, 1'b0);
            @(posedge clk); #2;
        end
        if (wr) m_wresp = 1'b1;
        else begin m_rvalid = 1'b1; m_rdata = rdata; end
        #1;
        chkb("d_dataok", d_dataok, 1'b1);
        if (!wr) chk("d_rdata", d_rdata, rdata);
        @(posedge clk); #1;
        m_wresp = 1'b0; m_rvalid = 1'b0;
        #1;
        chkb("d_dataok_end", d_dataok, 1'b0);
        chkb("d_idle_m_req", m_req, 1'b0);
    endtask

    task automatic txn_inst(input logic [2:0] typ, input logic [31:0] addr, input int last_at,
                            input int ad, input int rd, input bit keep);
        int   beats;
        logic [31:0] dat;
        beats = (typ == 3'b100) ? L : 1;
        i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
        #1;
        chkb("i_rd_rdy_grant", i_rd_rdy, 1'b1);
        chkb("d_addrok_quiet", d_addrok, 1'b0);
        model_last_inst = 1'b1;
        @(posedge clk); #1;
        if (!keep) begin
            i_rd_req = 1'b0; i_rd_addr = ~addr; i_rd_type = ~typ;
        end
        #1;
        chkb("i_rd_rdy_pulse", i_rd_rdy, 1'b0);
        chkb("i_m_req", m_req, 1'b1);
        chkb("i_m_wr", m_wr, 1'b0);
        chk("i_m_wstrb", 32'(m_wstrb), 32'd0);
        chk("i_m_len", 32'(m_len), 32'(beats - 1));
        chk("i_m_addr", m_addr, addr);
        repeat (ad) begin
            @(posedge clk); #2;
            chkb("i_m_req_hold", m_req, 1'b1);
            chk("i_m_len_hold", 32'(m_len), 32'(beats - 1));
        end
        m_addr_ok = 1'b1;
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        for (int b = 1; b <= last_at; b++) begin
            m_rvalid = 1'b0; m_rlast = 1'b0;
            repeat (rd) begin
                #1;
                chkb("i_ret_valid_gap", i_ret_valid, 1'b0);
                @(posedge clk); #1;
            end
            dat = $urandom;
            m_rvalid = 1'b1; m_rlast = (b == last_at); m_rdata = dat;
            #1;
            chkb("i_ret_valid", i_ret_valid, 1'b1);
            chkb("i_ret_last", i_ret_last, (b == last_at));
            chk("i_ret_data", i_ret_data, dat);
            chkb("i_d_dataok_quiet", d_dataok, 1'b0);
            @(posedge clk); #1;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        if (last_at != beats) model_err = 1'b1;
        #1;
        chkb("i_ret_valid_end", i_ret_valid, 1'b0);
        chkb("i_idle_m_req", m_req, 1'b0);
        chkb("i_proto_err", proto_err, model_err);
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        #1;
        chkb("rst_m_req", m_req, 1'b0);
        chkb("rst_i_rd_rdy", i_rd_rdy, 1'b0);
        chkb("rst_d_addrok", d_addrok, 1'b0);
        chkb("rst_proto_err", proto_err, 1'b0);
        chkb("rst_d_dataok", d_dataok, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        model_last_inst = 1'b1;
        model_err = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        i_rd_req = 1'b0; i_rd_type = 3'd0; i_rd_addr = 32'd0;
        d_req = 1'b0; d_wr = 1'b0; d_size = 3'd0; d_addr = 32'd0; d_wstrb = 4'd0; d_wdata = 32'd0;
        m_addr_ok = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = 32'd0; m_wresp = 1'b0;
        model_last_inst = 1'b1;
        model_err = 1'b0;

        #12;
        d_req = 1'b1;
        #1;
        chkb("reset_d_addrok", d_addrok, 1'b0);
        chkb("reset_m_req", m_req, 1'b0);
        chkb("reset_proto_err", proto_err, 1'b0);
        chk("reset_m_addr", m_addr, 32'd0);
        d_req = 1'b0;
        #9;
        resetn = 1'b1;
        @(posedge clk); #1;

        txn_data(1'b0, 3'd2, 32'h0000_1000, 4'hF, 32'd0, 32'hDEAD_BEEF, 2, 0, 1'b0);
        txn_inst(3'b100, 32'hBFC0_0000, L, 0, 0, 1'b0);
        txn_data(1'b1, 3'd1, 32'h0000_2002, 4'b0011, 32'h1234_5678, 32'd0, 1, 2, 1'b0);

        do_reset();
        d_req = 1'b1; i_rd_req = 1'b1; i_rd_type = 3'd0; i_rd_addr = 32'h0000_0400;
        txn_data(1'b0, 3'd2, 32'h0000_3000, 4'hF, 32'd0, 32'hA5A5_0001, 0, 0, 1'b1);
        txn_inst(3'd0, 32'h0000_0400, 1, 0, 0, 1'b1);
        txn_data(1'b0, 3'd2, 32'h0000_3000, 4'hF, 32'd0, 32'hA5A5_0002, 0, 0, 1'b1);
        txn_inst(3'd0, 32'h0000_0400, 1, 0, 0, 1'b0);
        txn_data(1'b0, 3'd2, 32'h0000_3000, 4'hF, 32'd0, 32'hA5A5_0003, 0, 0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            pat     = int'($urandom_range(0, 2));
            adly    = int'($urandom_range(0, 3));
            rdly    = int'($urandom_range(0, 2));
            r_wr    = 1'($urandom_range(0, 1));
            r_size  = 3'($urandom_range(0, 2));
            r_addr  = $urandom;
            r_iaddr = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_wstrb = 4'($urandom_range(0, 15));
            r_typ   = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 3));
            i_last  = (r_typ == 3'b100) ? L : 1;
            if (pat == 0) begin
                txn_data(r_wr, r_size, r_addr, r_wstrb, r_wdata, r_rdata, adly, rdly, 1'b0);
            end else if (pat == 1) begin
                txn_inst(r_typ, r_iaddr, i_last, adly, rdly, 1'b0);
            end else begin
                i_rd_req = 1'b1; i_rd_type = r_typ; i_rd_addr = r_iaddr;
                d_req = 1'b1; d_wr = r_wr; d_addr = r_addr;
                if (model_last_inst) begin
                    txn_data(r_wr, r_size, r_addr, r_wstrb, r_wdata, r_rdata, adly, rdly, 1'b0);
                    txn_inst(r_typ, r_iaddr, i_last, adly, rdly, 1'b0);
                end else begin
                    txn_inst(r_typ, r_iaddr, i_last, adly, rdly, 1'b0);
                    txn_data(r_wr, r_size, r_addr, r_wstrb, r_wdata, r_rdata, adly, rdly, 1'b0);
                end
            end
        end
        chkb("rand_proto_err", proto_err, 1'b0);

        m_wresp = 1'b1;
        #1;
        chkb("stray_d_dataok", d_dataok, 1'b0);
        @(posedge clk); #1;
        m_wresp = 1'b0;
        model_err = 1'b1;
        #1;
        chkb("stray_proto_err", proto_err, model_err);

        do_reset();
        txn_inst(3'b100, 32'h0000_8000, 2, 0, 0, 1'b0);
        txn_data(1'b0, 3'd2, 32'h0000_1004, 4'hF, 32'd0, 32'h0BAD_CAFE, 0, 1, 1'b0);
        chkb("sticky_proto_err", proto_err, 1'b1);

        do_reset();
        i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h8000_0040;
        #1;
        chkb("mid_i_rd_rdy", i_rd_rdy, 1'b1);
        @(posedge clk); #1;
        i_rd_req = 1'b0; m_addr_ok = 1'b1;
        @(posedge clk); #1;
        m_addr_ok = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        #1;
        chkb("mid_beat2_valid", i_ret_valid, 1'b1);
        #1;
        resetn = 1'b0; d_req = 1'b1; i_rd_req = 1'b1;
        #1;
        chkb("mid_rst_i_ret_valid", i_ret_valid, 1'b0);
        chk("mid_rst_i_ret_data", i_ret_data, 32'd0);
        chkb("mid_rst_m_req", m_req, 1'b0);
        chkb("mid_rst_d_addrok", d_addrok, 1'b0);
        chkb("mid_rst_i_rd_rdy", i_rd_rdy, 1'b0);
        chkb("mid_rst_proto_err", proto_err, 1'b0);
        m_rvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_last_inst = 1'b1;
        model_err = 1'b0;
        txn_data(1'b0, 3'd2, 32'h0000_5000, 4'hF, 32'd0, 32'h5555_AAAA, 0, 0, 1'b0);
        txn_inst(3'b100, 32'h8000_0040, L, 1, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
